// File: rtl/dw_accum_update.sv
// dw_accum_update: accumulates per-weight gradients dgate*x and applies w -= grad >>> LR_SHIFT on request.
module dw_accum_update #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 24,
  parameter int NUM      = 64,
  parameter int ADDR     = 6,
  parameter int LR_SHIFT = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_dgate,
  input  logic signed [WIDTH-1:0] i_x,
  input  logic [ADDR-1:0]         i_addr,
  input  logic                    i_apply,
  output logic                    o_busy,
  output logic [ADDR-1:0]         o_w_addr,
  input  logic signed [WIDTH-1:0] i_w,
  output logic                    o_w_wr,
  output logic [ADDR-1:0]         o_w_wr_addr,
  output logic signed [WIDTH-1:0] o_w_new,
  output logic                    o_done,
  output logic                    o_sat
);
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {CLEAR, IDLE, UPDATE, DRAIN} state_t;
  state_t                   state;
  logic signed [WIDTH-1:0]  grad [NUM];
  logic [ADDR-1:0]          cnt, s1_addr, s2_addr, rd_addr;
  logic                     s1_v, s2_v, rd_v, pend;
  logic signed [WIDTH-1:0]  s1_p, s1_g, s2_sum, g_rd, g_eff, p_val, sum_val, upd_val;
  logic signed [2*WIDTH-1:0] prod;
  logic                     p_sat, sum_sat, upd_sat, idle, acc, start;
  function automatic logic [WIDTH:0] sat(input logic signed [2*WIDTH-1:0] v);
    return (v > (2*WIDTH)'(MAXV)) ? {1'b1, MAXV} :
           (v < (2*WIDTH)'(MINV)) ? {1'b1, MINV} : {1'b0, v[WIDTH-1:0]};
  endfunction
  assign idle   = state == IDLE;
  assign o_busy = !idle;
  assign acc    = i_valid && idle && (int'(i_addr) < NUM);
  assign start  = idle && (i_apply || pend) && !s1_v && !acc;
  assign prod   = (2*WIDTH)'(i_dgate) * (2*WIDTH)'(i_x);
  // the previous term's write lands on the same edge this term's read was taken, so forward it
  assign g_eff  = (s2_v && s2_addr == s1_addr) ? s2_sum : s1_g;
  assign {p_sat, p_val}     = sat(prod >>> FRAC);
  assign {sum_sat, sum_val} = sat((2*WIDTH)'(g_eff) + (2*WIDTH)'(s1_p));
  assign {upd_sat, upd_val} = sat((2*WIDTH)'(i_w) - (2*WIDTH)'(g_rd >>> LR_SHIFT));
  always_ff @(posedge clk) begin
    if (state == CLEAR) grad[cnt] <= '0;
    else if (state == UPDATE) grad[o_w_addr] <= '0;
    else if (s1_v) grad[s1_addr] <= sum_val;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= CLEAR;
      cnt         <= '0;
      {s1_v, s2_v, rd_v, pend} <= '0;
      {s1_addr, s2_addr, rd_addr} <= '0;
      {s1_p, s1_g, s2_sum, g_rd} <= '0;
      o_w_addr    <= '0;
      o_w_wr      <= 1'b0;
      o_w_wr_addr <= '0;
      o_w_new     <= '0;
      o_done      <= 1'b0;
      o_sat       <= 1'b0;
    end else begin
      s1_v        <= acc;
      s1_addr     <= i_addr;
      s1_p        <= p_val;
      s1_g        <= grad[i_addr];
      s2_v        <= s1_v;
      s2_addr     <= s1_addr;
      s2_sum      <= sum_val;
      rd_v        <= state == UPDATE;
      rd_addr     <= o_w_addr;
      g_rd        <= grad[o_w_addr];
      o_w_wr      <= rd_v;
      o_w_wr_addr <= rd_addr;
      o_w_new     <= upd_val;
      o_done      <= state == DRAIN && cnt == ADDR'(1);
      o_sat       <= start ? 1'b0 : o_sat | (acc & p_sat) | (s1_v & sum_sat) | (rd_v & upd_sat);
      pend        <= idle && (pend || i_apply) && !start;
      case (state)
        CLEAR: begin
          cnt   <= cnt == ADDR'(NUM-1) ? '0 : cnt + 1'b1;
          state <= cnt == ADDR'(NUM-1) ? IDLE : CLEAR;
        end
        IDLE: begin
          o_w_addr <= '0;
          state    <= start ? UPDATE : IDLE;
        end
        UPDATE: begin
          cnt      <= '0;
          o_w_addr <= o_w_addr == ADDR'(NUM-1) ? o_w_addr : o_w_addr + 1'b1;
          state    <= o_w_addr == ADDR'(NUM-1) ? DRAIN : UPDATE;
        end
        default: begin
          cnt      <= cnt == ADDR'(1) ? '0 : cnt + 1'b1;
          o_w_addr <= '0;
          state    <= cnt == ADDR'(1) ? IDLE : DRAIN;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dw_accum_update.sv
// tb_dw_accum_update: directed checks of accumulation, forwarding, saturation, busy drop and abort.
module tb_dw_accum_update;
  localparam int NUM = 64;
  logic        clk = 1'b0, rst = 1'b0, i_valid = 1'b0, i_apply = 1'b0;
  logic [31:0] i_dgate = '0, i_x = '0, i_w;
  logic [5:0]  i_addr = '0;
  logic        o_busy, o_w_wr, o_done, o_sat;
  logic [5:0]  o_w_addr, o_w_wr_addr;
  logic [31:0] o_w_new;
  logic [31:0] wmem [NUM];
  logic        fill = 1'b0;
  logic [31:0] fill_val = '0;
  int          cyc = 0, nwr = 0, ndone = 0, errors = 0, checks = 0, dt = 0;

  dw_accum_update dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_dgate(i_dgate), .i_x(i_x),
    .i_addr(i_addr), .i_apply(i_apply), .o_busy(o_busy), .o_w_addr(o_w_addr),
    .i_w(i_w), .o_w_wr(o_w_wr), .o_w_wr_addr(o_w_wr_addr), .o_w_new(o_w_new),
    .o_done(o_done), .o_sat(o_sat)
  );

  always #5 clk = ~clk;

  // weight memory with one-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    i_w <= wmem[o_w_addr];
    if (fill) for (int i = 0; i < NUM; i++) wmem[i] <= fill_val;
    else if (o_w_wr) begin
      wmem[o_w_wr_addr] <= o_w_new;
      nwr <= nwr + 1;
    end
    if (o_done) ndone <= ndone + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill_w(input logic [31:0] v);
    fill_val = v;
    fill = 1'b1;
    @(negedge clk);
    fill = 1'b0;
  endtask

  task automatic term(input logic [31:0] d, input logic [31:0] x, input logic [5:0] a);
    i_valid = 1'b1; i_dgate = d; i_x = x; i_addr = a;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic release_and_count(input string tag);
    int k;
    rst = 1'b1;
    check({tag, "_outs"}, {17'b0, o_w_wr, o_done, o_sat, o_w_addr, o_w_wr_addr}, 32'h0);
    check({tag, "_wnew"}, o_w_new, 32'h0);
    k = 0;
    while (o_busy && k < 1000) begin
      k++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, k, NUM);
  endtask

  task automatic apply(input bit inject, input bit abort);
    int k, t0, base, nd0;
    base = nwr;
    nd0  = ndone;
    i_apply = 1'b1;
    @(negedge clk);
    i_apply = 1'b0;
    k = 0;
    while (!o_busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("sweep_start", o_busy, 1);
    t0 = cyc;
    if (inject) begin
      i_valid = 1'b1; i_dgate = 32'h01000000; i_x = 32'h01000000; i_addr = 6'd5;
      repeat (3) @(negedge clk);
      i_valid = 1'b0;
    end
    if (abort) begin
      k = 0;
      while (!(o_w_wr && o_w_wr_addr == 6'd9) && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("abort_at9", o_w_wr_addr, 9);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_wr_low", o_w_wr, 0);
      @(negedge clk);
      check("abort_nwr", nwr - base, 10);
      check("abort_no_done", ndone - nd0, 0);
      release_and_count("reclear");
      return;
    end
    k = 0;
    while (!o_done && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", o_done, 1);
    dt = cyc - t0;
    check("sweep_nwr", nwr - base, NUM);
    @(negedge clk);
    check("done_pulse", o_done, 0);
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    check("reset_busy", o_busy, 1);
    release_and_count("rst");
    // 1: clean sweep leaves weights unchanged
    fill_w(32'h01000000);
    apply(1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < NUM; i++) if (wmem[i] !== 32'h01000000) bad++;
    check("t1_unchanged", bad, 0);
    check("t1_sweep_len", dt, NUM + 2);
    check("t1_sat", o_sat, 0);
    // 2: back-to-back same address, apply while pipe still full
    fill_w(32'h01000000);
    term(32'h00800000, 32'h02000000, 6'd3);
    term(32'h00800000, 32'h02000000, 6'd3);
    apply(1'b0, 1'b0);
    check("t2_w3", wmem[3], 32'h00FC0000);
    check("t2_w2", wmem[2], 32'h01000000);
    // 3: negative gradient, then cleared
    fill_w(32'h0);
    term(32'hFF800000, 32'h01000000, 6'd0);
    apply(1'b0, 1'b0);
    check("t3_w0", wmem[0], 32'h00010000);
    fill_w(32'h0);
    apply(1'b0, 1'b0);
    check("t3_w0_cleared", wmem[0], 32'h0);
    // 4: product saturation then weight underflow clamp
    term(32'h7F000000, 32'h7F000000, 6'd7);
    repeat (2) @(negedge clk);
    check("t4_sat_acc", o_sat, 1);
    fill_w(32'h80000000);
    i_apply = 1'b1;
    @(negedge clk);
    i_apply = 1'b0;
    check("t4_sat_cleared", o_sat, 0);
    for (int k = 0; k < 300 && !o_done; k++) @(negedge clk);
    check("t4_done", o_done, 1);
    check("t4_w7", wmem[7], 32'h80000000);
    check("t4_w6", wmem[6], 32'h80000000);
    check("t4_sat_reset", o_sat, 1);
    @(negedge clk);
    // 5: terms during a sweep are dropped
    fill_w(32'h0);
    apply(1'b1, 1'b0);
    check("t5_sweep_len", dt, NUM + 2);
    fill_w(32'h0);
    apply(1'b0, 1'b0);
    check("t5_w5", wmem[5], 32'h0);
    // 6: reset mid-sweep, gradients re-cleared
    term(32'h01000000, 32'h01000000, 6'd20);
    fill_w(32'h01000000);
    apply(1'b0, 1'b1);
    fill_w(32'h01000000);
    apply(1'b0, 1'b0);
    check("t6_w20", wmem[20], 32'h01000000);
    bad = 0;
    for (int i = 0; i < NUM; i++) if (wmem[i] !== 32'h01000000) bad++;
    check("t6_unchanged", bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
